game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 13 +
 rtl/game_lfsr.sv | 16 +
 rtl/game_ctrl.sv | 107 ++++++++++
 tb/tb_game_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: state encoding, colour constants and LFSR taps shared by the game controller.
package game_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_SHOW, S_GAP, S_WAIT, S_CHECK, S_WIN, S_LOSE
  } state_t;
  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } colour_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/game_lfsr.sv
// game_lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting left each cycle.
module game_lfsr
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] value
);
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign value  = lfsr_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr_q <= seed;
    else lfsr_q <= lfsr_d;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: colour-sequence memory game sequencer (generate, show, wait, check, grow or finish).
module game_ctrl
  import game_pkg::*;
#(
  parameter int          MAX_LEN     = 8,
  parameter int          SHOW_CYCLES = 4,
  parameter int          GAP_CYCLES  = 2,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        complete_wait,
  input  logic [31:0] player_seq,
  output logic        wait_en,
  output logic [3:0]  sequence_len,
  output logic [1:0]  show_colour,
  output logic        show_valid,
  output logic        win,
  output logic        lose,
  output logic        busy
);
  localparam logic [7:0] SHOW_T   = 8'(SHOW_CYCLES - 1);
  localparam logic [7:0] GAP_T    = 8'(GAP_CYCLES - 1);
  localparam logic [3:0] LAST_LEN = 4'(MAX_LEN);
  state_t      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [3:0]  len_q, len_d, idx_q, idx_d;
  logic [7:0]  timer_q, timer_d;
  logic [15:0] lfsr_value;
  logic [13:0] lfsr_unused;
  logic [1:0]  lfsr_colour;
  logic [31:0] mask;
  logic        match;
  game_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .value(lfsr_value)
  );
  assign {lfsr_unused, lfsr_colour} = lfsr_value;
  // Only the slots played so far take part in the compare.
  assign mask  = (32'd1 << {len_q, 1'b0}) - 32'd1;
  assign match = ((player_seq ^ target_q) & mask) == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
    end
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    len_d        = len_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    wait_en      = state_q == S_WAIT;
    show_valid   = state_q == S_SHOW;
    show_colour  = show_valid ? target_q[{idx_q, 1'b0} +: 2] : RED;
    win          = state_q == S_WIN;
    lose         = state_q == S_LOSE;
    busy         = !(state_q inside {S_IDLE, S_WIN, S_LOSE});
    sequence_len = len_q;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE:
        if (start) begin
          state_d  = S_GEN;
          len_d    = 4'd1;
          target_d = '0;
        end
      S_GEN: begin
        target_d[{len_q - 4'd1, 1'b0} +: 2] = lfsr_colour;
        idx_d   = '0;
        timer_d = SHOW_T;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        state_d = timer_q == '0 ? S_GAP : S_SHOW;
        timer_d = timer_q == '0 ? GAP_T : timer_q - 8'd1;
      end
      S_GAP:
        if (timer_q != '0) timer_d = timer_q - 8'd1;
        else if (idx_q == len_q - 4'd1) begin
          state_d = S_WAIT;
          idx_d   = '0;
        end else begin
          state_d = S_SHOW;
          idx_d   = idx_q + 4'd1;
          timer_d = SHOW_T;
        end
      S_WAIT: state_d = complete_wait ? S_CHECK : S_WAIT;
      S_CHECK: begin
        state_d = !match ? S_LOSE : (len_q == LAST_LEN ? S_WIN : S_GEN);
        len_d   = match && len_q != LAST_LEN ? len_q + 4'd1 : len_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: randomized and directed bench for game_ctrl against a timeline-based reference model.
module tb_game_ctrl;
  localparam int ML  = 2;
  localparam int SC  = 4;
  localparam int GC  = 2;
  localparam int PER = SC + GC;
  logic        clk = 0, rst = 0, start = 0, complete_wait = 0;
  logic [31:0] player_seq = 0;
  logic        wait_en, show_valid, win, lose, busy;
  logic [1:0]  show_colour;
  logic [3:0]  sequence_len;
  int          vectors = 0, miscompares = 0;
  // model: phase 0 idle, 1 generating/showing, 2 waiting, 3 checking, 4 won, 5 lost
  int          ph, len, t;
  logic [1:0]  col[16];
  logic [15:0] m_lfsr;

  game_ctrl #(.MAX_LEN(ML), .SHOW_CYCLES(SC), .GAP_CYCLES(GC), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .complete_wait(complete_wait),
    .player_seq(player_seq), .wait_en(wait_en), .sequence_len(sequence_len),
    .show_colour(show_colour), .show_valid(show_valid), .win(win), .lose(lose), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [31:0] tgt();
    logic [31:0] p = 0;
    for (int k = 0; k < len; k++) p[2*k +: 2] = col[k];
    return p;
  endfunction

  function automatic logic [31:0] msk();
    return len == 0 ? 32'd0 : (32'hFFFF_FFFF >> (32 - 2 * len));
  endfunction

  function automatic logic [31:0] outs();
    return {21'd0, sequence_len, busy, win, lose, wait_en, show_valid, show_colour};
  endfunction

  function automatic logic [31:0] model_exp();
    logic       sv = 0;
    logic [1:0] sc = 0;
    if (ph == 1 && t > 0) begin
      sv = ((t - 1) % PER) < SC;
      sc = sv ? col[(t - 1) / PER] : 2'd0;
    end
    return {21'd0, 4'(len), ph inside {1, 2, 3}, ph == 4, ph == 5, ph == 2, sv, sc};
  endfunction

  task automatic model_reset();
    ph = 0; len = 0; t = 0; m_lfsr = 16'hACE1;
    for (int k = 0; k < 16; k++) col[k] = 0;
  endtask

  task automatic model_step();
    if (!rst) begin
      model_reset();
      return;
    end
    if (ph == 0 || ph == 4 || ph == 5) begin
      if (start) begin
        ph = 1; len = 1; t = 0;
        for (int k = 0; k < 16; k++) col[k] = 0;
      end
    end else if (ph == 1) begin
      if (t == 0) begin
        col[len - 1] = m_lfsr[1:0];
        t = 1;
      end else if (t == len * PER) ph = 2;
      else t++;
    end else if (ph == 2) begin
      if (complete_wait) ph = 3;
    end else if (ph == 3) begin
      if (((player_seq ^ tgt()) & msk()) != 0) ph = 5;
      else if (len == ML) ph = 4;
      else begin
        len++; ph = 1; t = 0;
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_for(input int which, input string name);
    for (int i = 0; i < 200; i++) begin
      if ((which == 0 && show_valid) || (which == 1 && wait_en) || (which == 3 && !show_valid)) return;
      @(negedge clk);
    end
    check({name, " timeout"}, 0, 1);
  endtask

  task automatic answer(input int kind);
    wait_for(1, "wait_en");
    player_seq = kind == 0 ? tgt() : kind == 1 ? tgt() ^ 32'd1 : tgt() | ~msk();
    complete_wait = 1;
    @(negedge clk);
    complete_wait = 0;
    check("in check", 32'({busy, wait_en}), 32'b10);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      model_step();
    end
  end

  initial forever begin
    @(posedge clk);
    #1 check("cycle", outs(), model_exp());
  end

  initial begin
    int hi, lo;
    repeat (3) @(negedge clk);
    check("reset outputs", outs(), 0);
    rst = 1; start = 1;
    @(negedge clk);
    start = 0;
    check("gen", 32'({busy, show_valid, sequence_len}), 32'b1_0_0001);
    @(negedge clk);
    check("first colour", 32'(show_colour), 3);
    hi = 0;
    while (show_valid && hi < 20) begin hi++; @(negedge clk); end
    check("show cycles", hi, 4);
    lo = 0;
    while (!wait_en && lo < 20) begin lo++; @(negedge clk); end
    check("gap cycles", lo, 2);
    check("len in wait", 32'(sequence_len), 1);
    answer(0);
    check("len after match", 32'(sequence_len), 2);
    wait_for(0, "round2 show");
    check("kept colour", 32'(show_colour), 3);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_for(3, "round2 gap");
    complete_wait = 1;
    @(negedge clk);
    complete_wait = 0;
    check("ignored pulses", 32'({sequence_len, busy, wait_en}), 32'b0010_1_0);
    answer(2);
    check("win", 32'({win, lose, busy}), 32'b100);
    repeat (4) @(negedge clk);
    check("win held", 32'({win, busy}), 32'b10);
    start = 1;
    @(negedge clk);
    start = 0;
    answer(1);
    check("lose", 32'({lose, busy, win}), 32'b100);
    repeat (4) @(negedge clk);
    check("lose held", 32'(lose), 1);
    start = 1;
    @(negedge clk);
    start = 0;
    check("lose cleared", 32'({lose, busy}), 32'b01);
    wait_for(0, "pre-reset show");
    #2 rst = 0;
    #1 check("reset mid show", outs(), 0);
    @(negedge clk);
    rst = 1; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    check("seed colour again", 32'({show_valid, show_colour}), 32'b111);
    wait_for(1, "pre-reset wait");
    #2 rst = 0;
    #1 check("reset mid wait", outs(), 0);
    @(negedge clk);
    rst = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start = $urandom_range(0, 9) == 0;
      if (ph != 3) begin
        complete_wait = $urandom_range(0, 3) == 0;
        if (len > 0 && $urandom_range(0, 3) == 0)
          player_seq = tgt() ^ (32'd1 << $urandom_range(0, 2 * len - 1));
        else
          player_seq = (tgt() & msk()) | ($urandom() & ~msk());
      end else complete_wait = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 0;
        #1 check("random reset", outs(), 0);
        @(negedge clk);
        rst = 1;
      end
    end
    start = 0; complete_wait = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
